embedded_io_soc_ctrl: RTL and testbench

EMBEDDED_IO_SOC_CTRL -- requirements
Module: embedded_io_soc_ctrl

---
 rtl/embedded_io_pkg.sv | 31 +++
 rtl/embedded_io_soc_ctrl_if.sv | 22 ++
 rtl/embedded_io_soc_ctrl_core.sv | 135 +++++++++++++
 rtl/embedded_io_sync2.sv | 23 ++
 rtl/embedded_io_soc_ctrl.sv | 63 ++++++
 tb/tb_embedded_io_soc_ctrl.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/embedded_io_pkg.sv
// Shared register map, CTRL bit positions and isolation FSM encoding for the
// embedded I/O SoC controller.
package embedded_io_pkg;

    localparam logic [1:0] REG_DATA_OUT = 2'd0;
    localparam logic [1:0] REG_DATA_IN  = 2'd1;
    localparam logic [1:0] REG_DIR      = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ACTIVE = 2;
    localparam int CTRL_IRQ    = 3;

    localparam logic [1:0] ST_ISOLATED  = 2'd0;
    localparam logic [1:0] ST_RELEASING = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;
    localparam logic [1:0] ST_ISOLATING = 2'd3;

    function automatic logic [3:0] ctrl_status(input logic irq, input logic active,
                                               input logic irq_en, input logic en);
        logic [3:0] s;
        s              = '0;
        s[CTRL_EN]     = en;
        s[CTRL_IRQ_EN] = irq_en;
        s[CTRL_ACTIVE] = active;
        s[CTRL_IRQ]    = irq;
        return s;
    endfunction

endpackage

// File: rtl/embedded_io_soc_ctrl_if.sv
// Register request/response bus between a host and the embedded I/O controller.
interface embedded_io_soc_ctrl_if #(
    parameter int NUM_IO = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_addr;
    logic [NUM_IO-1:0] req_wdata;
    logic              rsp_valid;
    logic [NUM_IO-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/embedded_io_soc_ctrl_core.sv
// Register file, pad isolation sequencer and edge-pending interrupt logic,
// operating on already-synchronized fabric inputs.
module embedded_io_soc_ctrl_core
    import embedded_io_pkg::*;
#(
    parameter int NUM_IO       = 16,
    parameter int GUARD_CYCLES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    embedded_io_soc_ctrl_if.slave  bus,
    input  logic [NUM_IO-1:0]      sync_out_i,
    input  logic [NUM_IO-1:0]      sync_dir_i,
    output logic [NUM_IO-1:0]      soc_in_o,
    output logic                   io_isol_n_o,
    output logic                   irq_o
);
    localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_IO-1:0] dout_q, dout_d;
    logic [NUM_IO-1:0] pend_q, pend_d;
    logic [NUM_IO-1:0] rdata_q, rdata_d;
    logic [NUM_IO-1:0] prev_q;
    logic              en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic              rsp_q, act_q;
    logic              accept, wr, active;
    logic [NUM_IO-1:0] pend_set, pend_clr;

    assign active = (state_q == ST_ACTIVE);
    assign accept = bus.req_valid && !rsp_q;
    assign wr     = accept && bus.req_we;

    always_comb begin
        rdata_d = '0;
        if (accept && !bus.req_we) begin
            case (bus.req_addr)
                REG_DATA_OUT: rdata_d = dout_q;
                REG_DATA_IN:  rdata_d = sync_out_i;
                REG_DIR:      rdata_d = sync_dir_i;
                default:      rdata_d = NUM_IO'(ctrl_status(irq_q, active, irq_en_q, en_q));
            endcase
        end
    end

    always_comb begin
        dout_d   = dout_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        pend_clr = '0;
        if (wr) begin
            case (bus.req_addr)
                REG_DATA_OUT: dout_d = bus.req_wdata;
                REG_DATA_IN:  pend_clr = bus.req_wdata;
                REG_CTRL: begin
                    en_d     = bus.req_wdata[CTRL_EN];
                    irq_en_d = bus.req_wdata[CTRL_IRQ_EN];
                end
                default: ;
            endcase
        end
    end

    // act_q masks the first ACTIVE cycle so an edge is never taken against a
    // sample captured while the pads were still isolated.
    assign pend_set = (active && act_q) ? ((sync_out_i ^ prev_q) & sync_dir_i) : '0;
    assign pend_d   = (pend_q & ~pend_clr) | pend_set;
    assign irq_d    = irq_en_d && |pend_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ISOLATED: begin
                if (en_q) begin
                    state_d = ST_RELEASING;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_RELEASING: begin
                if (!en_q)             state_d = ST_ISOLATED;
                else if (cnt_q == '0)  state_d = ST_ACTIVE;
                else                   cnt_d   = cnt_q - 1'b1;
            end
            ST_ACTIVE: begin
                if (!en_q) begin
                    state_d = ST_ISOLATING;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                if (cnt_q == '0) state_d = ST_ISOLATED;
                else             cnt_d   = cnt_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_ISOLATED;
            cnt_q    <= '0;
            dout_q   <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            pend_q   <= '0;
            prev_q   <= '0;
            act_q    <= 1'b0;
            irq_q    <= 1'b0;
            rsp_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            prev_q   <= sync_out_i;
            act_q    <= active;
            irq_q    <= irq_d;
            rsp_q    <= accept;
            rdata_q  <= rdata_d;
        end
    end

    // Isolation re-asserts in the same cycle EN is seen low, ahead of the state change.
    assign io_isol_n_o   = active && en_q;
    assign soc_in_o      = active ? dout_q : '0;
    assign irq_o         = irq_q;
    assign bus.req_ready = !rsp_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: rtl/embedded_io_sync2.sv
// Two-flop synchronizer for a vector of independent asynchronous bits.
module embedded_io_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q, s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/embedded_io_soc_ctrl.sv
// Embedded I/O SoC controller top: flat register-bus pins, input synchronizers
// and the controller core.
module embedded_io_soc_ctrl
    import embedded_io_pkg::*;
#(
    parameter int NUM_IO       = 16,
    parameter int GUARD_CYCLES = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_addr,
    input  logic [NUM_IO-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [NUM_IO-1:0] rsp_rdata,
    output logic [NUM_IO-1:0] soc_in_o,
    input  logic [NUM_IO-1:0] soc_out_i,
    input  logic [NUM_IO-1:0] soc_dir_i,
    output logic              io_isol_n_o,
    output logic              irq_o
);
    embedded_io_soc_ctrl_if #(.NUM_IO(NUM_IO)) bus_if ();

    logic [NUM_IO-1:0] sync_out, sync_dir;

    assign bus_if.req_valid = req_valid;
    assign bus_if.req_we    = req_we;
    assign bus_if.req_addr  = req_addr;
    assign bus_if.req_wdata = req_wdata;
    assign req_ready        = bus_if.req_ready;
    assign rsp_valid        = bus_if.rsp_valid;
    assign rsp_rdata        = bus_if.rsp_rdata;

    embedded_io_sync2 #(.W(NUM_IO)) u_sync_out (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (soc_out_i),
        .q_o   (sync_out)
    );

    embedded_io_sync2 #(.W(NUM_IO)) u_sync_dir (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (soc_dir_i),
        .q_o   (sync_dir)
    );

    embedded_io_soc_ctrl_core #(
        .NUM_IO       (NUM_IO),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_core (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .bus         (bus_if.slave),
        .sync_out_i  (sync_out),
        .sync_dir_i  (sync_dir),
        .soc_in_o    (soc_in_o),
        .io_isol_n_o (io_isol_n_o),
        .irq_o       (irq_o)
    );
endmodule

// File: tb/tb_embedded_io_soc_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a phase/age behavioural model of the controller.
module tb_embedded_io_soc_ctrl;
    localparam int N = 16;
    localparam int G = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] so_out = '0;
    logic [N-1:0] so_dir = '0;
    logic [N-1:0] soc_in;
    logic         isol_n, irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    embedded_io_soc_ctrl_if #(.NUM_IO(N)) bus ();

    embedded_io_soc_ctrl #(.NUM_IO(N), .GUARD_CYCLES(G)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid   (bus.req_valid),
        .req_ready   (bus.req_ready),
        .req_we      (bus.req_we),
        .req_addr    (bus.req_addr),
        .req_wdata   (bus.req_wdata),
        .rsp_valid   (bus.rsp_valid),
        .rsp_rdata   (bus.rsp_rdata),
        .soc_in_o    (soc_in),
        .soc_out_i   (so_out),
        .soc_dir_i   (so_dir),
        .io_isol_n_o (isol_n),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: pads are in one of four phases; 'age' counts cycles
    // spent in the current phase, guard phases last exactly G cycles.
    typedef enum int {P_ISO, P_REL, P_ACT, P_LEAVE} phase_e;
    phase_e       ph;
    int           age;
    logic [N-1:0] m_dout, m_pend, m_rdata;
    bit           m_en, m_ien, m_irq, m_rsp;
    logic [N-1:0] oh [3];
    logic [N-1:0] dh [3];

    always @(posedge clk or posedge rst) begin
        bit           acc;
        logic [N-1:0] setm, clrm, rd;
        phase_e       nph;
        if (rst) begin
            ph = P_ISO; age = 1; m_dout = '0; m_pend = '0; m_rdata = '0;
            m_en = 0; m_ien = 0; m_irq = 0; m_rsp = 0;
            for (int i = 0; i < 3; i++) begin oh[i] = '0; dh[i] = '0; end
        end else begin
            acc  = bus.req_valid && !m_rsp;
            // oh[1]/dh[1] are the synchronized values, oh[2] the previous one
            setm = (ph == P_ACT && age >= 2) ? ((oh[1] ^ oh[2]) & dh[1]) : '0;
            clrm = (acc && bus.req_we && bus.req_addr == 2'd1) ? bus.req_wdata : '0;
            rd   = '0;
            if (acc && !bus.req_we) begin
                case (bus.req_addr)
                    2'd0: rd = m_dout;
                    2'd1: rd = oh[1];
                    2'd2: rd = dh[1];
                    default: rd[3:0] = {m_irq, ph == P_ACT, m_ien, m_en};
                endcase
            end
            nph = ph;
            case (ph)
                P_ISO:   if (m_en) nph = P_REL;
                P_REL:   if (!m_en) nph = P_ISO; else if (age == G) nph = P_ACT;
                P_ACT:   if (!m_en) nph = P_LEAVE;
                default: if (age == G) nph = P_ISO;
            endcase
            age = (nph != ph) ? 1 : age + 1;
            ph  = nph;
            if (acc && bus.req_we && bus.req_addr == 2'd0) m_dout = bus.req_wdata;
            if (acc && bus.req_we && bus.req_addr == 2'd3) begin
                m_en  = bus.req_wdata[0];
                m_ien = bus.req_wdata[1];
            end
            m_pend  = (m_pend & ~clrm) | setm;
            m_irq   = m_ien && (m_pend != '0);
            m_rsp   = acc;
            m_rdata = rd;
            oh[2] = oh[1]; oh[1] = oh[0]; oh[0] = so_out;
            dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = so_dir;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("req_ready", bus.req_ready, !m_rsp);
            chk("rsp_valid", bus.rsp_valid, m_rsp);
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
            chk("soc_in_o", soc_in, (ph == P_ACT) ? m_dout : '0);
            chk("io_isol_n_o", isol_n, ph == P_ACT && m_en);
            chk("irq_o", irq, m_irq);
        end
    end

    int           acc_cyc;
    logic [N-1:0] rd_last;
    logic         rsp_seen, isol_at_acc, irq_at_acc;

    task automatic do_req(input bit we, input logic [1:0] a, input logic [N-1:0] d);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk); #1;
        acc_cyc = cyc; rd_last = bus.rsp_rdata; rsp_seen = bus.rsp_valid;
        isol_at_acc = isol_n; irq_at_acc = irq;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        @(posedge clk); #1;
    endtask

    task automatic wait_isol(output int edges);
        int t0;
        t0 = acc_cyc;
        for (int i = 0; i < 80 && !isol_n; i++) begin
            @(posedge clk); #1;
        end
        edges = cyc - t0;
    endtask

    initial begin
        int e, lat, a_clr;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        @(posedge clk); #2;
        chk("rst req_ready", bus.req_ready, 1);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst rsp_rdata", bus.rsp_rdata, 0);
        chk("rst soc_in_o", soc_in, 0);
        chk("rst io_isol_n_o", isol_n, 0);
        chk("rst irq_o", irq, 0);
        @(posedge clk); #1;
        rst = 1'b0; chk_on = 1'b1;
        @(posedge clk); #1;

        do_req(1, 2'd0, 16'h00A5);
        do_req(0, 2'd0, '0);
        chk("read reg0 valid", rsp_seen, 1);
        chk("read reg0 data", rd_last, 16'h00A5);
        chk("soc_in isolated", soc_in, 0);

        do_req(1, 2'd3, 16'h0003);
        wait_isol(e);
        chk("release latency", e, G + 1);
        chk("soc_in active", soc_in, 16'h00A5);

        so_dir = 16'h0001;
        repeat (4) @(posedge clk); #1;
        so_out[1] = ~so_out[1];
        repeat (5) @(posedge clk); #1;
        chk("bit1 no pend", irq, 0);
        so_out[0] = ~so_out[0];
        lat = 0;
        while (!irq && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("irq within 4", lat <= 4, 1);
        do_req(0, 2'd3, '0);
        chk("ctrl status", rd_last, 16'h000F);

        do_req(1, 2'd1, 16'h0001);
        chk("w1c irq low", irq_at_acc, 0);
        so_out[0] = ~so_out[0];
        repeat (2) @(posedge clk); #1;
        do_req(1, 2'd1, 16'h0001);
        chk("w1c+edge keeps", irq_at_acc, 1);
        chk("w1c+edge later", irq, 1);
        do_req(1, 2'd1, 16'h0001);
        chk("w1c alone low", irq_at_acc, 0);

        do_req(1, 2'd3, 16'h0002);
        a_clr = acc_cyc;
        chk("isol drop", isol_at_acc, 0);
        do_req(1, 2'd3, 16'h0003);
        acc_cyc = a_clr;
        wait_isol(e);
        chk("re-release latency", e, 2 * G + 2);

        so_out[0] = ~so_out[0];
        repeat (4) @(posedge clk); #1;
        chk("irq before rst", irq, 1);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 2'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid rst rsp_valid", bus.rsp_valid, 0);
        chk("mid rst rsp_rdata", bus.rsp_rdata, 0);
        chk("mid rst req_ready", bus.req_ready, 1);
        chk("mid rst soc_in_o", soc_in, 0);
        chk("mid rst io_isol_n_o", isol_n, 0);
        chk("mid rst irq_o", irq, 0);
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) so_out = so_out ^ (N'(1) << $urandom_range(0, N - 1));
            if ($urandom_range(0, 31) == 0) so_out = N'($urandom);
            if ($urandom_range(0, 15) == 0) so_dir = N'($urandom);
            bus.req_valid = ($urandom_range(0, 2) == 0);
            bus.req_we    = $urandom_range(0, 1) == 1;
            bus.req_addr  = 2'($urandom_range(0, 3));
            bus.req_wdata = N'($urandom);
            if (bus.req_addr == 2'd3) bus.req_wdata[0] = ($urandom_range(0, 7) != 0);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
